// File: rtl/filter_type_sequencer_pkg.sv
// filter_pkg: shared definitions for the filter-type sequencer.
//   state_t  - sequencer FSM states
//   ftype_t  - pole-tap encodings (LP1 = 1-pole ... LP4 = 4-pole)
//   ZONE_B*  - CC zone boundaries
//   zone_lo  - lowest CC value belonging to a zone
package filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FADE_OUT,
        ST_SWITCH,
        ST_SETTLE,
        ST_FADE_IN
    } state_t;

    typedef enum logic [1:0] {
        LP1 = 2'd0,
        LP2 = 2'd1,
        LP3 = 2'd2,
        LP4 = 2'd3
    } ftype_t;

    localparam logic [7:0] ZONE_B1 = 8'd32;
    localparam logic [7:0] ZONE_B2 = 8'd64;
    localparam logic [7:0] ZONE_B3 = 8'd96;

    function automatic logic [7:0] zone_lo(input logic [1:0] z);
        logic [7:0] lo;
        case (z)
            2'd0:    lo = 8'd0;
            2'd1:    lo = ZONE_B1;
            2'd2:    lo = ZONE_B2;
            default: lo = ZONE_B3;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/filter_type_sequencer_if.sv
// Bus between the MIDI CC register file / tick source (master) and the
// filter-type sequencer (slave).
//   tick, cc_valid, filter_type_cc : master -> slave
//   type_sel, gain, busy, switch_done : slave -> master
interface filter_type_sequencer_if #(
    parameter int unsigned GAIN_W = 8
);
    logic              tick;
    logic              cc_valid;
    logic [6:0]        filter_type_cc;
    logic [1:0]        type_sel;
    logic [GAIN_W-1:0] gain;
    logic              busy;
    logic              switch_done;

    modport master (
        output tick, cc_valid, filter_type_cc,
        input  type_sel, gain, busy, switch_done
    );

    modport slave (
        input  tick, cc_valid, filter_type_cc,
        output type_sel, gain, busy, switch_done
    );
endinterface

// File: rtl/filter_type_sequencer_cc_zone_hyst.sv
// cc_zone_hyst: CC-to-target decode with hysteresis; owns the target register.
//   clk, rst        - clock, async active-high reset
//   cc_valid, cc    - CC update strobe and value
//   target          - hysteresis-stable requested filter type
module cc_zone_hyst
    import filter_pkg::*;
#(
    parameter int unsigned HYST = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cc_valid,
    input  logic [6:0] cc,
    output ftype_t     target
);

    ftype_t     target_q, target_d;
    logic [1:0] zone;
    logic [8:0] cc_w, lo_w;
    logic       up_ok, dn_ok;

    always_comb begin
        zone  = cc[6:5];
        cc_w  = {2'b00, cc};
        lo_w  = {1'b0, zone_lo(zone)};
        // Must be at least HYST inside the new zone, measured from the edge we cross.
        up_ok = cc_w >= lo_w + 9'(HYST);
        dn_ok = cc_w + 9'(HYST) <= lo_w + 9'd31;

        target_d = target_q;
        if (cc_valid && (zone != 2'(target_q))) begin
            if (zone > 2'(target_q)) begin
                if (up_ok) target_d = ftype_t'(zone);
            end else begin
                if (dn_ok) target_d = ftype_t'(zone);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) target_q <= LP1;
        else     target_q <= target_d;
    end

    assign target = target_q;

endmodule

// File: rtl/filter_type_sequencer.sv
// filter_type_sequencer: click-free pole-tap switch controller.
// Fades the output gain to zero, switches the tap, settles, then fades back in.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of filter_type_sequencer_if
//              (tick, cc_valid, filter_type_cc in; type_sel, gain, busy, switch_done out)
module filter_type_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned GAIN_W       = 8,
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned SETTLE_TICKS = 64,
    parameter int unsigned HYST         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    filter_type_sequencer_if.slave   bus
);

    localparam int unsigned GW1   = GAIN_W + 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

    ftype_t              target;
    state_t              state_q, state_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    ftype_t              type_sel_q, type_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [GAIN_W:0]     gain_up, gain_dn;
    logic [GAIN_W-1:0]   gain_up_sat, gain_dn_sat;

    cc_zone_hyst #(
        .HYST (HYST)
    ) u_hyst (
        .clk      (clk),
        .rst      (rst),
        .cc_valid (bus.cc_valid),
        .cc       (bus.filter_type_cc),
        .target   (target)
    );

    // Ramp arithmetic in one extra bit so neither direction can wrap.
    always_comb begin
        gain_up     = {1'b0, gain_q} + GW1'(RAMP_STEP);
        gain_dn     = {1'b0, gain_q} - GW1'(RAMP_STEP);
        gain_up_sat = (gain_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up[GAIN_W-1:0];
        gain_dn_sat = gain_dn[GAIN_W] ? '0 : gain_dn[GAIN_W-1:0];
        cnt_inc     = cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        type_sel_d = type_sel_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gain_d = GAIN_MAX;
                if (target != type_sel_q) state_d = ST_FADE_OUT;
            end
            ST_FADE_OUT: begin
                if (target == type_sel_q)  state_d = ST_FADE_IN;
                else if (gain_q == '0)     state_d = ST_SWITCH;
                else if (bus.tick)         gain_d  = gain_dn_sat;
            end
            ST_SWITCH: begin
                type_sel_d = target;
                cnt_d      = '0;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                gain_d = '0;
                if (target != type_sel_q) begin
                    state_d = ST_FADE_OUT;
                end else if (bus.tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_W'(SETTLE_TICKS)) state_d = ST_FADE_IN;
                end
            end
            ST_FADE_IN: begin
                if (target != type_sel_q) begin
                    state_d = ST_FADE_OUT;
                end else if (gain_q == GAIN_MAX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (bus.tick) begin
                    gain_d = gain_up_sat;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gain_q     <= GAIN_MAX;
            type_sel_q <= LP1;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            type_sel_q <= type_sel_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.type_sel    = type_sel_q;
    assign bus.gain        = gain_q;
    assign bus.busy        = busy_q;
    assign bus.switch_done = done_q;

endmodule

// File: tb/tb_filter_type_sequencer.sv
module tb_filter_type_sequencer;

    logic clk;
    logic rst;
    int unsigned vec_cnt;
    int unsigned err_cnt;

    filter_type_sequencer_if #(.GAIN_W(8)) bus ();

    filter_type_sequencer #(
        .GAIN_W       (8),
        .RAMP_STEP    (1),
        .SETTLE_TICKS (64),
        .HYST         (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        vec_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cc(input int unsigned v);
        bus.cc_valid       = 1'b1;
        bus.filter_type_cc = 7'(v);
        step();
        bus.cc_valid       = 1'b0;
    endtask

    task automatic wait_gain(input int unsigned g, input string tag);
        for (int i = 0; i < 2000 && bus.gain != 8'(g); i++) step();
        check_eq(tag, bus.gain, g);
    endtask

    task automatic wait_sel(input int unsigned s, input string tag);
        for (int i = 0; i < 2000 && bus.type_sel != 2'(s); i++) step();
        check_eq(tag, bus.type_sel, s);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !bus.switch_done; i++) step();
        check_eq(tag, bus.switch_done, 1);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        vec_cnt            = 0;
        err_cnt            = 0;
        rst                = 1'b1;
        bus.tick           = 1'b0;
        bus.cc_valid       = 1'b0;
        bus.filter_type_cc = '0;
        step();
        step();
        check_eq("rst_sel",  bus.type_sel, 0);
        check_eq("rst_gain", bus.gain, 255);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.switch_done, 0);
        rst = 1'b0;
        step();

        // cc=20 stays in zone 0: nothing happens
        send_cc(20);
        step();
        step();
        check_eq("z0_busy", bus.busy, 0);
        check_eq("z0_gain", bus.gain, 255);

        // Full 0 -> 3 change, tick every cycle
        bus.tick = 1'b1;
        send_cc(100);
        check_eq("full_lat_busy", bus.busy, 0);
        step();
        check_eq("full_busy", bus.busy, 1);
        check_eq("full_g255", bus.gain, 255);
        for (int i = 0; i < 100; i++) step();
        check_eq("full_g155", bus.gain, 155);
        for (int i = 0; i < 155; i++) step();
        check_eq("full_g0", bus.gain, 0);
        check_eq("full_sel_pre", bus.type_sel, 0);
        step();
        check_eq("full_sw_sel", bus.type_sel, 0);
        step();
        check_eq("full_sel3", bus.type_sel, 3);
        for (int i = 0; i < 64; i++) step();
        check_eq("full_settle_g0", bus.gain, 0);
        step();
        check_eq("full_fi_g1", bus.gain, 1);
        for (int i = 0; i < 254; i++) step();
        check_eq("full_fi_g255", bus.gain, 255);
        check_eq("full_fi_busy", bus.busy, 1);
        check_eq("full_fi_done", bus.switch_done, 0);
        step();
        check_eq("full_done", bus.switch_done, 1);
        check_eq("full_idle", bus.busy, 0);
        step();
        check_eq("full_done_pulse", bus.switch_done, 0);

        // Hysteresis
        send_cc(40);
        wait_done("to1_done");
        check_eq("to1_sel", bus.type_sel, 1);
        step();
        send_cc(64);
        step();
        check_eq("hyst64", bus.busy, 0);
        send_cc(65);
        step();
        check_eq("hyst65", bus.busy, 0);
        send_cc(66);
        step();
        check_eq("hyst66", bus.busy, 1);
        wait_done("to2_done");
        check_eq("to2_sel", bus.type_sel, 2);
        step();
        send_cc(63);
        step();
        check_eq("hyst63", bus.busy, 0);
        send_cc(61);
        step();
        check_eq("hyst61", bus.busy, 1);
        wait_done("back1_done");
        check_eq("back1_sel", bus.type_sel, 1);

        // Reversal during fade-out
        step();
        send_cc(10);
        wait_done("to0_done");
        check_eq("to0_sel", bus.type_sel, 0);
        step();
        send_cc(70);
        step();
        for (int i = 0; i < 154; i++) step();
        check_eq("rev_g101", bus.gain, 101);
        send_cc(10);
        check_eq("rev_g100", bus.gain, 100);
        step();
        check_eq("rev_hold", bus.gain, 100);
        step();
        check_eq("rev_up", bus.gain, 101);
        check_eq("rev_sel", bus.type_sel, 0);
        wait_done("rev_done");
        check_eq("rev_sel_end", bus.type_sel, 0);

        // Retarget during fade-in
        step();
        send_cc(40);
        wait_gain(0, "rt_g0");
        wait_sel(1, "rt_sel1");
        wait_gain(50, "rt_g50");
        send_cc(120);
        check_eq("rt_g51", bus.gain, 51);
        step();
        check_eq("rt_hold", bus.gain, 51);
        step();
        check_eq("rt_down", bus.gain, 50);
        wait_gain(0, "rt_g0b");
        check_eq("rt_sel_pre", bus.type_sel, 1);
        step();
        step();
        check_eq("rt_sel3", bus.type_sel, 3);
        wait_done("rt_done");
        check_eq("rt_gain_end", bus.gain, 255);

        // Async reset in SETTLE
        step();
        send_cc(70);
        wait_gain(0, "ar_g0");
        for (int i = 0; i < 5; i++) step();
        check_eq("ar_sel2", bus.type_sel, 2);
        check_eq("ar_settle_g", bus.gain, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_gain", bus.gain, 255);
        check_eq("ar_sel", bus.type_sel, 0);
        check_eq("ar_busy", bus.busy, 0);
        check_eq("ar_done", bus.switch_done, 0);
        step();
        check_eq("ar_done2", bus.switch_done, 0);
        rst = 1'b0;
        step();
        step();
        check_eq("ar_post_busy", bus.busy, 0);
        check_eq("ar_post_done", bus.switch_done, 0);
        check_eq("ar_post_gain", bus.gain, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
